fetch_stage: RTL and testbench

Instruction-fetch front end of the pipelined RV32 core. It owns the PC, issues in-order word requests to instruction memory, and buffers returned instructions with their PCs in a small queue. It presents them to the decode stage over a valid/ready handshake. Redirects from the branch/jump resolution logic flush in-flight work and restart fetch at the target.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_stage.sv | 139 +++++++++++++
 tb/tb_fetch_stage.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32 pipeline.
// Fetch-queue entry layout and reset defaults live here.
package riscv_pkg;

  localparam int RV_XLEN = 32;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  localparam logic [RV_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]        instr;
    logic [RV_XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is read straight from storage.
// Used for the fetch queue and for the outstanding-request pc tags.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != FULL) || do_pop);
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, credit-limited imem requests, fetch queue.
// Define FETCH_PERF_EN to add perf_fetched/perf_killed/perf_stall.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_killed,
  output logic [31:0]     perf_stall,
`endif
  input  logic            id_ready
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam int QW = $bits(fetch_entry_t);
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FQ_DEPTH);

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   kill;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   q_count;
  logic [XLEN-1:0] tag;
  logic [QW-1:0]   q_dout;
  fetch_entry_t    q_din;
  fetch_entry_t    q_head;
  logic            credit;
  logic            fire;
  logic            drop;
  logic            q_push;
  logic            q_pop;
  logic            unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];

  // credit covers both in-flight requests and buffered entries
  assign credit = ({1'b0, outstanding} + {1'b0, q_count}) < DEPTH_L;

  assign imem_req_valid = reset && !redirect_valid && credit;
  assign imem_req_addr  = pc;
  assign fire           = imem_req_valid && imem_req_ready;

  assign drop   = redirect_valid || (kill != '0);
  assign q_push = imem_rsp_valid && !drop;
  assign q_din  = '{instr: imem_rsp_data, pc: tag};

  assign id_valid = q_count != '0;
  assign q_pop    = id_valid && id_ready && !redirect_valid;
  assign q_head   = fetch_entry_t'(q_dout);
  assign id_instr = q_head.instr;
  assign id_pc    = q_head.pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc   <= RESET_PC;
      kill <= '0;
    end else if (redirect_valid) begin
      pc   <= {redirect_pc[XLEN-1:2], 2'b00};
      kill <= outstanding - CW'(imem_rsp_valid);
    end else begin
      if (fire) begin
        pc <= pc + XLEN'(4);
      end
      if (imem_rsp_valid && (kill != '0)) begin
        kill <= kill - CW'(1);
      end
    end
  end

  // tags are never flushed so killed responses still retire theirs
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FQ_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (1'b0),
    .push  (fire),
    .din   (pc),
    .pop   (imem_rsp_valid),
    .dout  (tag),
    .count (outstanding)
  );

  fetch_fifo #(
    .WIDTH (QW),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_q (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (q_push),
    .din   (q_din),
    .pop   (q_pop),
    .dout  (q_dout),
    .count (q_count)
  );

  rsp_needs_outstanding: assert property (
    @(posedge clk) disable iff (!reset)
    imem_rsp_valid |-> (outstanding != '0)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_killed  <= '0;
      perf_stall   <= '0;
    end else begin
      if (q_push) begin
        perf_fetched <= perf_fetched + 32'(1);
      end
      if (imem_rsp_valid && drop) begin
        perf_killed <= perf_killed + 32'(1);
      end
      if (id_valid && !id_ready) begin
        perf_stall <= perf_stall + 32'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage with a 1/2-cycle memory model.
// Expected PC streams are queued at reset/redirect and checked on pop.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready = 1'b0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_killed;
  logic [31:0] perf_stall;
`endif

  int          tests = 0;
  int          fails = 0;
  int          popped = 0;
  int          mem_lat = 1;
  logic        d_valid;
  logic [31:0] d_addr;
  logic [31:0] exp_pc;
  logic [31:0] exp_q [$];

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
`ifdef FETCH_PERF_EN
    .perf_fetched   (perf_fetched),
    .perf_killed    (perf_killed),
    .perf_stall     (perf_stall),
`endif
    .id_ready       (id_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  // in-order instruction memory, reset by the same signal as the DUT
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
      d_valid        <= 1'b0;
      d_addr         <= '0;
    end else if (mem_lat == 1) begin
      imem_rsp_valid <= imem_req_valid && imem_req_ready;
      imem_rsp_data  <= instr_of(imem_req_addr);
      d_valid        <= 1'b0;
    end else begin
      d_valid        <= imem_req_valid && imem_req_ready;
      d_addr         <= imem_req_addr;
      imem_rsp_valid <= d_valid;
      imem_rsp_data  <= instr_of(d_addr);
    end
  end

  always @(negedge clk) begin
    if (reset && id_valid && id_ready && !redirect_valid) begin
      tests++;
      popped++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_extra: got pc %h, required no entry", id_pc);
      end else begin
        exp_pc = exp_q.pop_front();
        if (id_pc !== exp_pc || id_instr !== instr_of(exp_pc)) begin
          fails++;
          $display("FAIL sb_order: got pc %h instr %h, required pc %h instr %h",
                   id_pc, id_instr, exp_pc, instr_of(exp_pc));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_stream(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(base + 32'(4 * i));
    end
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    step(2);
  endtask

  task automatic test_reset();
    hold_reset();
    tests += 5;
    if (id_valid !== 1'b0) begin
      fails++; $display("FAIL rst_id_valid: got %b, required 0", id_valid);
    end
    if (imem_req_valid !== 1'b0) begin
      fails++; $display("FAIL rst_req_valid: got %b, required 0", imem_req_valid);
    end
    if (id_instr !== 32'h0) begin
      fails++; $display("FAIL rst_id_instr: got %h, required 0", id_instr);
    end
    if (id_pc !== 32'h0) begin
      fails++; $display("FAIL rst_id_pc: got %h, required 0", id_pc);
    end
    if (imem_req_addr !== 32'h0) begin
      fails++; $display("FAIL rst_addr: got %h, required 0", imem_req_addr);
    end
  endtask

  task automatic test_basic();
    int first = 0;
    int vcnt = 0;
    int nfire = 0;
    int addr_err = 0;
    logic [31:0] next_addr = '0;
    mem_lat = 1;
    hold_reset();
    id_ready = 1'b1;
    start_stream(32'h0);
    reset = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        nfire++;
        if (imem_req_addr !== next_addr) addr_err++;
        next_addr += 32'd4;
      end
      if (first == 0 && id_valid) begin
        first = c;
        tests++;
        if (id_pc !== 32'h0) begin
          fails++; $display("FAIL basic_first_pc: got %h, required 0", id_pc);
        end
      end else if (first != 0 && id_valid) begin
        vcnt++;
      end
    end
    tests += 4;
    if (first != 3) begin
      fails++; $display("FAIL basic_latency: got cycle %0d, required 3", first);
    end
    if (vcnt != 17) begin
      fails++; $display("FAIL basic_rate: got %0d valid cycles, required 17", vcnt);
    end
    if (nfire != 20) begin
      fails++; $display("FAIL basic_fires: got %0d, required 20", nfire);
    end
    if (addr_err != 0) begin
      fails++; $display("FAIL basic_addr: got %0d bad addrs, required 0", addr_err);
    end
  endtask

  task automatic test_stall();
    int fires = 0;
    int stalls = 0;
    int p0;
    mem_lat = 1;
    hold_reset();
    id_ready = 1'b0;
    start_stream(32'h0);
    reset = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) fires++;
      if (id_valid && !id_ready) stalls++;
    end
    tests += 2;
    if (fires != 4) begin
      fails++; $display("FAIL stall_fires: got %0d, required 4", fires);
    end
    if (imem_req_valid !== 1'b0) begin
      fails++; $display("FAIL stall_req_valid: got %b, required 0", imem_req_valid);
    end
    step(1);
`ifdef FETCH_PERF_EN
    tests++;
    if (perf_stall !== 32'(stalls)) begin
      fails++; $display("FAIL perf_stall: got %0d, required %0d", perf_stall, stalls);
    end
`endif
    id_ready = 1'b1;
    p0 = popped;
    step(20);
    tests++;
    if (popped - p0 < 16) begin
      fails++; $display("FAIL stall_drain: got %0d pops, required >=16", popped - p0);
    end
  endtask

  task automatic test_redirect();
    int seen = 0;
    int p0;
`ifdef FETCH_PERF_EN
    logic [31:0] k0;
`endif
    mem_lat = 2;
    hold_reset();
    id_ready = 1'b1;
    start_stream(32'h0);
    reset = 1'b1;
    step(8);
`ifdef FETCH_PERF_EN
    k0 = perf_killed;
`endif
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    start_stream(32'h100);
    #1;
    tests++;
    if (imem_req_valid !== 1'b0) begin
      fails++; $display("FAIL redir_no_req: got %b, required 0", imem_req_valid);
    end
    step(1);
    redirect_valid = 1'b0;
    #1;
    tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      fails++;
      $display("FAIL redir_addr: got valid %b addr %h, required 1 100",
               imem_req_valid, imem_req_addr);
    end
    for (int c = 1; c <= 10 && seen == 0; c++) begin
      @(negedge clk);
      if (id_valid) seen = c;
    end
    tests++;
    if (seen == 0 || id_pc !== 32'h100) begin
      fails++; $display("FAIL redir_first_pc: got %h, required 100", id_pc);
    end
    p0 = popped;
    step(10);
    tests++;
    if (popped - p0 < 8) begin
      fails++; $display("FAIL redir_flow: got %0d pops, required >=8", popped - p0);
    end
`ifdef FETCH_PERF_EN
    tests++;
    if (perf_killed - k0 !== 32'd2) begin
      fails++; $display("FAIL perf_killed: got %0d, required 2", perf_killed - k0);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int seen = 0;
    mem_lat = 1;
    hold_reset();
    id_ready = 1'b1;
    start_stream(32'h0);
    reset = 1'b1;
    step(6);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    start_stream(32'h304);
    step(1);
    redirect_pc = 32'h0000_0306;
    step(1);
    redirect_valid = 1'b0;
    #1;
    tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h304) begin
      fails++;
      $display("FAIL b2b_addr: got valid %b addr %h, required 1 304",
               imem_req_valid, imem_req_addr);
    end
    for (int c = 1; c <= 10 && seen == 0; c++) begin
      @(negedge clk);
      if (id_valid) seen = c;
    end
    tests++;
    if (seen != 3 || id_pc !== 32'h304) begin
      fails++;
      $display("FAIL b2b_latency: got cycle %0d pc %h, required 3 304", seen, id_pc);
    end
    step(8);
  endtask

  task automatic test_req_stall();
    int found = 0;
    int held = 0;
    mem_lat = 1;
    hold_reset();
    id_ready = 1'b1;
    start_stream(32'h0);
    reset = 1'b1;
    for (int c = 0; c < 20 && found == 0; c++) begin
      step(1);
      if (imem_req_valid && imem_req_addr == 32'h20) found = 1;
    end
    imem_req_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step(1);
      if (imem_req_valid === 1'b1 && imem_req_addr === 32'h20) held++;
    end
    tests++;
    if (found == 0 || held != 5) begin
      fails++; $display("FAIL req_hold: got %0d held cycles, required 5", held);
    end
    imem_req_ready = 1'b1;
    step(1);
    tests++;
    if (imem_req_addr !== 32'h24) begin
      fails++; $display("FAIL req_advance: got %h, required 24", imem_req_addr);
    end
    step(10);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    mem_lat = 1;
    hold_reset();
    id_ready = 1'b0;
    start_stream(32'h0);
    reset = 1'b1;
    step(4);
    tests++;
    if (id_valid !== 1'b1) begin
      fails++; $display("FAIL mid_filled: got %b, required 1", id_valid);
    end
    reset = 1'b0;
    #1;
    tests += 3;
    if (id_valid !== 1'b0) begin
      fails++; $display("FAIL mid_id_valid: got %b, required 0", id_valid);
    end
    if (imem_req_valid !== 1'b0) begin
      fails++; $display("FAIL mid_req_valid: got %b, required 0", imem_req_valid);
    end
    if (imem_req_addr !== 32'h0) begin
      fails++; $display("FAIL mid_addr: got %h, required 0", imem_req_addr);
    end
`ifdef FETCH_PERF_EN
    tests++;
    if (perf_fetched !== 32'h0) begin
      fails++; $display("FAIL perf_rst: got %0d, required 0", perf_fetched);
    end
`endif
    step(1);
    start_stream(32'h0);
    id_ready = 1'b1;
    reset = 1'b1;
    for (int c = 1; c <= 10 && seen == 0; c++) begin
      @(negedge clk);
      if (id_valid) seen = c;
    end
    tests++;
    if (seen == 0 || id_pc !== 32'h0) begin
      fails++; $display("FAIL mid_restart: got pc %h, required 0", id_pc);
    end
    step(10);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_req_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule
